// File: rtl/mmc1.sv
// MMC1 (SxROM) mapper: serial register file, PRG/CHR banking and mirroring.
// Define MMC1_RMW_FILTER_EN to ignore a serial write landing one CPU cycle after another.
module mmc1 #(
   parameter int PRG_AW = 21,
   parameter int CHR_AW = 21
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cputick,
   input  logic [15:0]       memaddr,
   input  logic [7:0]        memwdata,
   input  logic              memwr,
   input  logic              prgreq,
   output logic              prgack,
   output logic [7:0]        prgrdata,
   input  logic [13:0]       vmemaddr,
   input  logic [7:0]        vmemwdata,
   input  logic              vmemwr,
   input  logic              chrreq,
   output logic              chrack,
   output logic [7:0]        chrrdata,
   output logic [PRG_AW-1:0] promaddr,
   output logic              promreq,
   input  logic              promack,
   input  logic [7:0]        promdata,
   output logic [CHR_AW-1:0] cromaddr,
   output logic              cromreq,
   input  logic              cromack,
   input  logic [7:0]        cromdata,
   output logic [12:0]       chrramaddr,
   output logic [7:0]        chrramwdata,
   output logic              chrramwr,
   output logic              chrramreq,
   input  logic              chrramack,
   input  logic [7:0]        chrramrdata,
   output logic [12:0]       wramaddr,
   output logic [7:0]        wramwdata,
   output logic              wramwr,
   output logic              wramreq,
   input  logic              wramack,
   input  logic [7:0]        wramrdata,
   input  logic [127:0]      header,
   output logic [2:0]        mirr
);

   localparam logic [1:0] C_IDLE = 2'd0, C_ROM = 2'd1, C_WRAM = 2'd2, C_ACK = 2'd3;
   localparam logic [1:0] V_IDLE = 2'd0, V_CROM = 2'd1, V_CRAM = 2'd2, V_ACK = 2'd3;

`ifdef MMC1_RMW_FILTER_EN
   localparam logic RMW_FILTER = 1'b1;
`else
   localparam logic RMW_FILTER = 1'b0;
`endif

   logic [4:0]  control, chr0, chr1, prg, shift, shift_next;
   logic [1:0]  cpu_state, chr_state;
   logic        seen_wr, last_wr, reg_wr, wr_ignored;
   logic [7:0]  byte4, byte5, prg_bank;
   logic [31:0] prg_full, prg_mask, prg_addr, chr_full, chr_mask, chr_addr;
   logic        unused_bits;

   assign byte4      = header[39:32];
   assign byte5      = header[47:40];
   assign reg_wr     = (cpu_state == C_IDLE) && prgreq && memwr && memaddr[15];
   assign wr_ignored = RMW_FILTER && last_wr;
   assign shift_next = {memwdata[0], shift[4:1]};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      prg_bank = 8'h00;
      case (control[3:2])
         2'b10:   prg_bank = memaddr[14] ? {4'b0, prg[3:0]} : 8'h00;
         2'b11:   prg_bank = memaddr[14] ? byte4 - 8'd1 : {4'b0, prg[3:0]};
         default: prg_bank = {4'b0, prg[3:1], memaddr[14]};
      endcase
   end

   assign prg_full = {10'b0, prg_bank, memaddr[13:0]};
   assign prg_mask = {10'b0, byte4, 14'b0} - 32'd1;
   assign prg_addr = prg_full & prg_mask;

   always_comb begin
      chr_full = {15'b0, chr0[4:1], vmemaddr[12:0]};
      if (control[4])
         chr_full = {15'b0, (vmemaddr[12] ? chr1 : chr0), vmemaddr[11:0]};
   end

   assign chr_mask = {11'b0, byte5, 13'b0} - 32'd1;
   assign chr_addr = chr_full & chr_mask;

   always_comb begin
      mirr = 3'd2;
      case (control[1:0])
         2'd0: mirr = 3'd2;
         2'd1: mirr = 3'd3;
         2'd2: mirr = 3'd1;
         2'd3: mirr = 3'd0;
      endcase
   end

   assign unused_bits = ^{header[127:48], header[31:0], vmemaddr[13],
                          prg_addr[31:PRG_AW], chr_addr[31:CHR_AW]};

   // Tracks whether the previous CPU cycle carried a register write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seen_wr <= 1'b0;
         last_wr <= 1'b0;
      end else if (cputick) begin
         last_wr <= seen_wr | reg_wr;
         seen_wr <= 1'b0;
      end else if (reg_wr) begin
         seen_wr <= 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_state <= C_IDLE;
         control   <= 5'h0C;
         chr0      <= 5'h00;
         chr1      <= 5'h00;
         prg       <= 5'h00;
         shift     <= 5'b10000;
         prgack    <= 1'b0;
         prgrdata  <= 8'h00;
         promaddr  <= '0;
         promreq   <= 1'b0;
         wramaddr  <= 13'h0;
         wramwdata <= 8'h00;
         wramwr    <= 1'b0;
         wramreq   <= 1'b0;
      end else begin
         case (cpu_state)
            C_IDLE: if (prgreq) begin
               if (memwr && memaddr[15]) begin
                  if (!wr_ignored) begin
                     if (memwdata[7]) begin
                        shift   <= 5'b10000;
                        control <= control | 5'h0C;
                     end else if (shift[0]) begin
                        case (memaddr[14:13])
                           2'd0: control <= shift_next;
                           2'd1: chr0    <= shift_next;
                           2'd2: chr1    <= shift_next;
                           2'd3: prg     <= shift_next;
                        endcase
                        shift <= 5'b10000;
                     end else begin
                        shift <= shift_next;
                     end
                  end
                  prgack    <= 1'b1;
                  cpu_state <= C_ACK;
               end else if (memaddr[15]) begin
                  promaddr  <= prg_addr[PRG_AW-1:0];
                  promreq   <= 1'b1;
                  cpu_state <= C_ROM;
               end else if (memaddr[14:13] == 2'b11 && !prg[4]) begin
                  wramaddr  <= memaddr[12:0];
                  wramwdata <= memwdata;
                  wramwr    <= memwr;
                  wramreq   <= 1'b1;
                  cpu_state <= C_WRAM;
               end else begin
                  // Open bus and disabled work RAM answer immediately.
                  prgrdata  <= 8'hFF;
                  prgack    <= 1'b1;
                  cpu_state <= C_ACK;
               end
            end
            C_ROM: if (promack) begin
               promreq   <= 1'b0;
               prgrdata  <= promdata;
               prgack    <= 1'b1;
               cpu_state <= C_ACK;
            end
            C_WRAM: if (wramack) begin
               wramreq   <= 1'b0;
               wramwr    <= 1'b0;
               prgrdata  <= wramrdata;
               prgack    <= 1'b1;
               cpu_state <= C_ACK;
            end
            default: begin
               prgack    <= 1'b0;
               cpu_state <= C_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chr_state   <= V_IDLE;
         chrack      <= 1'b0;
         chrrdata    <= 8'h00;
         cromaddr    <= '0;
         cromreq     <= 1'b0;
         chrramaddr  <= 13'h0;
         chrramwdata <= 8'h00;
         chrramwr    <= 1'b0;
         chrramreq   <= 1'b0;
      end else begin
         case (chr_state)
            V_IDLE: if (chrreq) begin
               if (byte5 != 8'h00) begin
                  if (vmemwr) begin
                     chrack    <= 1'b1;
                     chr_state <= V_ACK;
                  end else begin
                     cromaddr  <= chr_addr[CHR_AW-1:0];
                     cromreq   <= 1'b1;
                     chr_state <= V_CROM;
                  end
               end else begin
                  chrramaddr  <= chr_full[12:0];
                  chrramwdata <= vmemwdata;
                  chrramwr    <= vmemwr;
                  chrramreq   <= 1'b1;
                  chr_state   <= V_CRAM;
               end
            end
            V_CROM: if (cromack) begin
               cromreq   <= 1'b0;
               chrrdata  <= cromdata;
               chrack    <= 1'b1;
               chr_state <= V_ACK;
            end
            V_CRAM: if (chrramack) begin
               chrramreq <= 1'b0;
               chrramwr  <= 1'b0;
               chrrdata  <= chrramrdata;
               chrack    <= 1'b1;
               chr_state <= V_ACK;
            end
            default: begin
               chrack    <= 1'b0;
               chr_state <= V_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmc1.sv
// Randomized bench for mmc1 against a behavioural mapper model; honours MMC1_RMW_FILTER_EN.
module tb_mmc1;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         cputick = 1'b0;
   logic [15:0]  memaddr = '0;
   logic [7:0]   memwdata = '0;
   logic         memwr = 1'b0;
   logic         prgreq = 1'b0;
   logic         prgack;
   logic [7:0]   prgrdata;
   logic [13:0]  vmemaddr = '0;
   logic [7:0]   vmemwdata = '0;
   logic         vmemwr = 1'b0;
   logic         chrreq = 1'b0;
   logic         chrack;
   logic [7:0]   chrrdata;
   logic [20:0]  promaddr;
   logic         promreq;
   logic         promack = 1'b0;
   logic [7:0]   promdata = '0;
   logic [20:0]  cromaddr;
   logic         cromreq;
   logic         cromack = 1'b0;
   logic [7:0]   cromdata = '0;
   logic [12:0]  chrramaddr;
   logic [7:0]   chrramwdata;
   logic         chrramwr;
   logic         chrramreq;
   logic         chrramack = 1'b0;
   logic [7:0]   chrramrdata = '0;
   logic [12:0]  wramaddr;
   logic [7:0]   wramwdata;
   logic         wramwr;
   logic         wramreq;
   logic         wramack = 1'b0;
   logic [7:0]   wramrdata = '0;
   logic [127:0] header = '0;
   logic [2:0]   mirr;

`ifdef MMC1_RMW_FILTER_EN
   localparam bit filt = 1'b1;
`else
   localparam bit filt = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Behavioural view of the mapper: register values and the serial bits collected so far.
   int m_control = 'h0C, m_chr0 = 0, m_chr1 = 0, m_prg = 0;
   int m_acc = 0, m_cnt = 0;
   bit m_cur_wr = 1'b0, m_prev_wr = 1'b0;

   // Responder bookkeeping.
   int prom_n = 0, prom_dly = 0, prom_ack_cyc = 0;
   int crom_n = 0, crom_dly = 0, crom_ack_cyc = 0;
   int wram_n = 0, wram_dly = 0, wram_ack_cyc = 0;
   int cram_n = 0, cram_dly = 0, cram_ack_cyc = 0;
   logic [31:0] prom_last = '0, crom_last = '0, wram_last = '0, cram_last = '0;
   logic        wram_last_wr = 1'b0, cram_last_wr = 1'b0;
   logic [7:0]  wram_last_d = '0, cram_last_d = '0;

   mmc1 dut (
      .clk(clk), .reset_n(reset_n), .cputick(cputick),
      .memaddr(memaddr), .memwdata(memwdata), .memwr(memwr),
      .prgreq(prgreq), .prgack(prgack), .prgrdata(prgrdata),
      .vmemaddr(vmemaddr), .vmemwdata(vmemwdata), .vmemwr(vmemwr),
      .chrreq(chrreq), .chrack(chrack), .chrrdata(chrrdata),
      .promaddr(promaddr), .promreq(promreq), .promack(promack), .promdata(promdata),
      .cromaddr(cromaddr), .cromreq(cromreq), .cromack(cromack), .cromdata(cromdata),
      .chrramaddr(chrramaddr), .chrramwdata(chrramwdata), .chrramwr(chrramwr),
      .chrramreq(chrramreq), .chrramack(chrramack), .chrramrdata(chrramrdata),
      .wramaddr(wramaddr), .wramwdata(wramwdata), .wramwr(wramwr),
      .wramreq(wramreq), .wramack(wramack), .wramrdata(wramrdata),
      .header(header), .mirr(mirr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] rom_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      return a[7:0] ^ a[12:5] ^ 8'h3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // Downstream memories answer after a random 0..3 cycle wait.
   always @(negedge clk) begin
      if (promack) promack = 1'b0;
      else if (promreq) begin
         if (prom_dly == 0) begin
            prom_last = 32'(promaddr); promdata = rom_byte(prom_last);
            promack = 1'b1; prom_n++; prom_ack_cyc = cyc; prom_dly = $urandom_range(0, 3);
         end else prom_dly--;
      end
      if (cromack) cromack = 1'b0;
      else if (cromreq) begin
         if (crom_dly == 0) begin
            crom_last = 32'(cromaddr); cromdata = rom_byte(crom_last);
            cromack = 1'b1; crom_n++; crom_ack_cyc = cyc; crom_dly = $urandom_range(0, 3);
         end else crom_dly--;
      end
      if (wramack) wramack = 1'b0;
      else if (wramreq) begin
         if (wram_dly == 0) begin
            wram_last = 32'(wramaddr); wram_last_wr = wramwr; wram_last_d = wramwdata;
            wramrdata = ram_byte(wram_last);
            wramack = 1'b1; wram_n++; wram_ack_cyc = cyc; wram_dly = $urandom_range(0, 3);
         end else wram_dly--;
      end
      if (chrramack) chrramack = 1'b0;
      else if (chrramreq) begin
         if (cram_dly == 0) begin
            cram_last = 32'(chrramaddr); cram_last_wr = chrramwr; cram_last_d = chrramwdata;
            chrramrdata = ram_byte(cram_last);
            chrramack = 1'b1; cram_n++; cram_ack_cyc = cyc; cram_dly = $urandom_range(0, 3);
         end else cram_dly--;
      end
   end

   function automatic int prg_exp(input logic [15:0] a);
      int b4 = int'(header[39:32]);
      int slot = int'(a[14]);
      int bank;
      case ((m_control >> 2) & 3)
         2:       bank = slot ? (m_prg & 15) : 0;
         3:       bank = slot ? b4 - 1 : (m_prg & 15);
         default: bank = (m_prg & 14) + slot;
      endcase
      return (bank * 16384 + (int'(a) % 16384)) % (b4 * 16384);
   endfunction

   function automatic int chr_lin(input logic [13:0] v);
      int vi = int'(v);
      if ((m_control & 'h10) == 0) return (m_chr0 / 2) * 8192 + vi % 8192;
      return ((vi >= 4096) ? m_chr1 : m_chr0) * 4096 + vi % 4096;
   endfunction

   function automatic int mirr_exp();
      case (m_control & 3)
         0: return 2;
         1: return 3;
         2: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [7:0] d);
      int b;
      if (!(filt && m_prev_wr)) begin
         if (d[7]) begin
            m_cnt = 0; m_acc = 0; m_control = m_control | 'h0C;
         end else begin
            b = int'(d[0]);
            m_acc = m_acc + (b << m_cnt);
            m_cnt++;
            if (m_cnt == 5) begin
               case (a[14:13])
                  2'd0: m_control = m_acc;
                  2'd1: m_chr0 = m_acc;
                  2'd2: m_chr1 = m_acc;
                  2'd3: m_prg = m_acc;
               endcase
               m_cnt = 0; m_acc = 0;
            end
         end
      end
      m_cur_wr = 1'b1;
   endtask

   task automatic tick();
      @(negedge clk);
      cputick = 1'b1;
      m_prev_wr = m_cur_wr;
      m_cur_wr = 1'b0;
      @(negedge clk);
      cputick = 1'b0;
   endtask

   task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic wr);
      int n = 0;
      int p0 = prom_n;
      int w0 = wram_n;
      int ea = prg_exp(a);
      bit wram_off = (m_prg & 'h10) != 0;
      @(negedge clk);
      memaddr = a; memwdata = d; memwr = wr; prgreq = 1'b1;
      while (!prgack && n < 64) begin
         @(negedge clk);
         n++;
      end
      prgreq = 1'b0; memwr = 1'b0;
      if (!prgack) begin
         check("prg timeout", 32'(prgack), 32'd1);
         return;
      end
      if (a[15] && wr) begin
         check("reg wr latency", n, 1);
         model_write(a, d);
         check("mirr", 32'(mirr), mirr_exp());
      end else if (a[15]) begin
         check("prom count", prom_n - p0, 1);
         check("promaddr", prom_last, ea);
         check("prg rdata", 32'(prgrdata), 32'(rom_byte(ea)));
         check("prom ack latency", cyc - prom_ack_cyc, 1);
      end else if (a[14:13] == 2'b11 && !wram_off) begin
         check("wram count", wram_n - w0, 1);
         check("wramaddr", wram_last, 32'(a[12:0]));
         check("wramwr", 32'(wram_last_wr), 32'(wr));
         if (wr) check("wramwdata", 32'(wram_last_d), 32'(d));
         else    check("wram rdata", 32'(prgrdata), 32'(ram_byte(32'(a[12:0]))));
         check("wram ack latency", cyc - wram_ack_cyc, 1);
      end else begin
         check("open bus latency", n, 1);
         check("no wram req", wram_n - w0, 0);
         if (!wr) check("open bus rdata", 32'(prgrdata), 32'hFF);
      end
      @(negedge clk);
      check("prgack pulse", 32'(prgack), 32'd0);
   endtask

   task automatic chr_op(input logic [13:0] v, input logic [7:0] d, input logic wr);
      int n = 0;
      int c0 = crom_n;
      int r0 = cram_n;
      int b5 = int'(header[47:40]);
      int ea = chr_lin(v);
      ea = (b5 != 0) ? ea % (b5 * 8192) : ea % 8192;
      @(negedge clk);
      vmemaddr = v; vmemwdata = d; vmemwr = wr; chrreq = 1'b1;
      while (!chrack && n < 64) begin
         @(negedge clk);
         n++;
      end
      chrreq = 1'b0; vmemwr = 1'b0;
      if (!chrack) begin
         check("chr timeout", 32'(chrack), 32'd1);
         return;
      end
      if (b5 != 0 && wr) begin
         check("chr rom write dropped", crom_n - c0, 0);
         check("chr rom write latency", n, 1);
      end else if (b5 != 0) begin
         check("crom count", crom_n - c0, 1);
         check("cromaddr", crom_last, ea);
         check("chr rdata", 32'(chrrdata), 32'(rom_byte(ea)));
         check("crom ack latency", cyc - crom_ack_cyc, 1);
      end else begin
         check("chrram count", cram_n - r0, 1);
         check("chrramaddr", cram_last, ea);
         check("chrramwr", 32'(cram_last_wr), 32'(wr));
         if (wr) check("chrramwdata", 32'(cram_last_d), 32'(d));
         else    check("chrram rdata", 32'(chrrdata), 32'(ram_byte(ea)));
      end
      @(negedge clk);
      check("chrack pulse", 32'(chrack), 32'd0);
   endtask

   task automatic wr8(input logic [15:0] a, input logic [7:0] d);
      cpu_op(a, d, 1'b1);
      tick();
      tick();
   endtask

   task automatic reg_serial(input logic [15:0] a, input logic [4:0] val);
      for (int i = 0; i < 5; i++) wr8(a, {7'b0, val[i]});
   endtask

   task automatic set_header(input logic [7:0] b4, input logic [7:0] b5);
      header = {$urandom, $urandom, $urandom, $urandom};
      header[39:32] = b4;
      header[47:40] = b5;
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      int          r;
      set_header(8'd8, 8'd4);
      repeat (3) @(negedge clk);
      check("rst prgack", 32'(prgack), 0);
      check("rst chrack", 32'(chrack), 0);
      check("rst reqs", 32'({promreq, cromreq, wramreq, chrramreq}), 0);
      check("rst wr", 32'({wramwr, chrramwr}), 0);
      check("rst rdata", 32'({prgrdata, chrrdata}), 0);
      check("rst mirr", 32'(mirr), 32'd2);
      reset_n = 1'b1;

      cpu_op(16'hFFFC, 8'h00, 1'b0);
      check("tp last bank", prom_last, 32'h1FFFC);
      reg_serial(16'hE000, 5'd5);
      cpu_op(16'h8000, 8'h00, 1'b0);
      check("tp prg5", prom_last, 32'h14000);

      wr8(16'h8000, 8'h01);
      wr8(16'h8000, 8'h01);
      wr8(16'h8000, 8'h80);
      cpu_op(16'hC123, 8'h00, 1'b0);
      check("tp reset mode3", prom_last, 32'h1C123);
      reg_serial(16'h8000, 5'h10);
      reg_serial(16'hC000, 5'd3);
      chr_op(14'h1234, 8'h00, 1'b0);
      check("tp chr 4k", crom_last, 32'h3234);
      reg_serial(16'h8000, 5'h00);
      reg_serial(16'hA000, 5'd3);
      chr_op(14'h1234, 8'h00, 1'b0);
      check("tp chr 8k", crom_last, 32'h3234);

      reg_serial(16'hE000, 5'h10);
      cpu_op(16'h6000, 8'h00, 1'b0);
      check("tp wram off", 32'(prgrdata), 32'hFF);
      set_header(8'd8, 8'd0);
      chr_op(14'h0100, 8'h5A, 1'b1);
      check("tp chrram addr", cram_last, 32'h100);
      check("tp chrram wr", 32'(cram_last_wr), 32'd1);

      wr8(16'h8000, 8'h80);
      cpu_op(16'h8000, 8'h01, 1'b1);
      tick();
      cpu_op(16'h8000, 8'h00, 1'b1);
      tick();
      tick();
      reg_serial(16'h8000, 5'b00001);
      check("tp rmw mirr", 32'(mirr), filt ? 32'd0 : 32'd3);

      for (int it = 0; it < 250; it++) begin
         if (it % 25 == 0) begin
            r = $urandom_range(0, 5);
            set_header(8'd1 << $urandom_range(1, 4), (r == 0) ? 8'd0 : 8'd1 << (r - 1));
         end
         r = $urandom_range(0, 9);
         if (r <= 2) begin
            a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            d = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 11) == 0) d = d | 8'h80;
            cpu_op(a, d, 1'b1);
         end else if (r <= 4) begin
            cpu_op(16'h8000 | 16'($urandom_range(0, 16'h7FFF)), 8'h00, 1'b0);
         end else if (r == 5) begin
            cpu_op(16'h6000 | 16'($urandom_range(0, 16'h1FFF)), 8'($urandom), 1'($urandom));
         end else if (r == 6) begin
            cpu_op(16'h4020 + 16'($urandom_range(0, 16'h1FDF)), 8'($urandom), 1'($urandom));
         end else if (r <= 8) begin
            chr_op(14'($urandom_range(0, 14'h1FFF)), 8'($urandom), 1'($urandom));
         end else begin
            a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            d = 8'($urandom_range(0, 127));
            fork
               cpu_op(a, d, 1'b1);
               chr_op(14'($urandom_range(0, 14'h1FFF)), 8'h00, 1'b0);
            join
         end
         tick();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmc1.md
Name: mmc1

Overview:
- MMC1 (SxROM) mapper controller; drop-in alternative to the NROM mapper, between the memory decoder and the ROM arbiter.
- Decodes CPU writes to $8000-$FFFF into the MMC1 serial register file (control, CHR0, CHR1, PRG).
- Translates CPU PRG reads and PPU CHR accesses into banked PRG-ROM / CHR-ROM / CHR-RAM / work-RAM requests.
- Drives the nametable mirroring code to the memory block.

Parameters:
- PRG_AW, 21, PRG-ROM byte address width.
- CHR_AW, 21, CHR-ROM byte address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cputick  in  1  one-cycle CPU cycle strobe
- memaddr  in  16  CPU bus address
- memwdata  in  8  CPU write data
- memwr  in  1  CPU write qualifier
- prgreq  in  1  CPU access to $6000-$FFFF, held until prgack
- prgack  out  1  one-cycle completion pulse
- prgrdata  out  8  CPU read data
- vmemaddr  in  14  PPU address
- vmemwdata  in  8  PPU write data
- vmemwr  in  1  PPU write qualifier
- chrreq  in  1  PPU access to $0000-$1FFF, held until chrack
- chrack  out  1  completion pulse
- chrrdata  out  8  PPU read data
- promaddr/promreq/promack/promdata  out/out/in/in  PRG_AW/1/1/8  PRG-ROM port
- cromaddr/cromreq/cromack/cromdata  out/out/in/in  CHR_AW/1/1/8  CHR-ROM port
- chrramaddr/chrramwdata/chrramwr/chrramreq/chrramack/chrramrdata  out/out/out/out/in/in  13/8/1/1/1/8
- wramaddr/wramwdata/wramwr/wramreq/wramack/wramrdata  out/out/out/out/in/in  13/8/1/1/1/8  8 KB work RAM
- header  in  128  iNES header; byte4 = header[39:32], PRG 16 KB units; byte5 = header[47:40], CHR 8 KB units, 0 means CHR-RAM
- mirr  out  3  0 horizontal, 1 vertical, 2 single-screen A, 3 single-screen B

Behaviour:
- Reset (reset_n low, asynchronous):
  - control=5'h0C, chr0=chr1=prg=0, shift=5'b10000 (sentinel).
  - FSMs go to IDLE; all req/ack/wr outputs 0; rdata outputs 0.
- Register write, CPU path: prgreq & memwr & memaddr[15] completes in one register stage; prgack pulses the cycle after IDLE samples the request.
  - memwdata[7]=1: shift<=10000, control<=control|5'h0C.
  - Otherwise: shift <= {memwdata[0], shift[4:1]}.
  - If the old shift[0]=1 (5th write), the value {memwdata[0], shift[4:1]} goes to the register chosen by memaddr[14:13] (0 control, 1 chr0, 2 chr1, 3 prg), and shift<=10000.
- CPU FSM: IDLE -> ROMRD | WRAM -> ACK -> IDLE.
  - Requests are sampled only in IDLE.
  - Downstream req asserts the cycle after sampling and is held until the downstream ack.
  - prgack pulses the cycle after the downstream ack; prgrdata latched with it.
- PRG read, memaddr[15]=1: bank by control[3:2].
  - 0,1: 32 KB, bank {prg[3:1],0}|A14.
  - 2: $8000 = bank 0, $C000 = prg[3:0].
  - 3: $8000 = prg[3:0], $C000 = last bank (byte4-1).
  - promaddr = {bank, memaddr[13:0]} masked to (byte4*16K - 1).
- $6000-$7FFF: wramreq with wramaddr = memaddr[12:0], wramwr = memwr.
  - If prg[4]=1 (RAM disabled): no wramreq; ack next cycle, reads return 8'hFF, writes dropped.
- $4020-$5FFF: ack next cycle, rdata 8'hFF.
- CHR FSM, independent of CPU FSM: same IDLE/REQ/ACK structure.
  - control[4]=0: 8 KB mode, addr = {chr0[4:1], vmemaddr[12:0]}.
  - control[4]=1: 4 KB mode, chr0 for $0000 and chr1 for $1000, addr = {bank, vmemaddr[11:0]}.
  - byte5 != 0: cromreq, address masked to (byte5*8K - 1); PPU writes acked and dropped.
  - byte5 = 0: chrramreq, chrramaddr = addr[12:0], honours vmemwr.
- mirr, combinational from control[1:0]: 0->2, 1->3, 2->1, 3->0.
- Simultaneous CPU and PPU requests proceed in parallel. A register write landing while a CHR access is in flight does not alter that access's latched address.
- Reset mid-transaction drops the request with no ack; the requester reissues.

Optional Feature:
- MMC1_RMW_FILTER_EN defined: a serial write (bit7=0 or 1) is ignored, though still acked, if the previous CPU cycle (prior cputick) also carried a $8000-$FFFF write. This matches hardware behaviour for INC/ROR double writes.
- Undefined: every write is processed.

Test Plan:
- Reset, then read $FFFC with byte4=8 -> promaddr=0x1C000+0x3FFC (mode 3 fixes last bank); prgack one cycle after promack.
- Five writes to $E000 of bits 1,0,1,0,0 (prg=5) then read $8000 -> promaddr=0x14000; shift back to 10000.
- Write $80 to $8000 after two serial writes -> shift cleared, control[3:2]=3; next five writes start clean.
- Control=0x10 (4 KB CHR), chr1=3, byte5=4, PPU read $1234 -> cromaddr=0x3234; control=0x00, chr0=3 -> $1234 maps to 0x03234.
- prg[4]=1, CPU read $6000 -> no wramreq, prgrdata=FF; byte5=0 PPU write $0100 -> chrramwr=1, chrramaddr=0x100.
- MMC1_RMW_FILTER_EN: back-to-back-cycle writes $01,$00 to $8000 -> only first shifted; without the macro both are shifted.
